// File: rtl/ring_counter_4bit.sv
// One-hot ring counter: a 2-bit binary up-counter feeding a 2-to-4 decoder.
// The count register is the only state; dout is purely decoded from it.

module ring_counter_4bit_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             rst,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Free-running; natural overflow provides the wrap back to zero.
  always_ff @(posedge clock) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module ring_counter_4bit_dec #(
  parameter int CNT_W   = 2,
  parameter int NUM_OUT = 4
) (
  input  logic [CNT_W-1:0]   i_cnt,
  output logic [NUM_OUT-1:0] o_dout
);
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_dec
    assign o_dout[g] = (i_cnt == CNT_W'(g));
  end
endmodule

module ring_counter_4bit (
  input  logic       clock,
  input  logic       rst,
  output logic [3:0] dout
);
  localparam int CNT_W   = 2;
  localparam int NUM_OUT = 4;

  logic [CNT_W-1:0] w_cnt;

  ring_counter_4bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .rst   (rst),
    .o_cnt (w_cnt)
  );

  ring_counter_4bit_dec #(.CNT_W(CNT_W), .NUM_OUT(NUM_OUT)) u_dec (
    .i_cnt  (w_cnt),
    .o_dout (dout)
  );
endmodule

// File: tb/tb_ring_counter_4bit.sv
// Scoreboard bench for ring_counter_4bit: stimulus queues expected dout per
// edge, a negedge monitor pops and compares and also checks one-hotness.

module tb_ring_counter_4bit;
  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] dout;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  logic [3:0] q[$];
  logic [3:0] m;

  ring_counter_4bit dut (
    .clock (clock),
    .rst   (rst),
    .dout  (dout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with rst driven to r; expected value pushed after the edge.
  task automatic step(input logic r, input logic [3:0] e);
    rst = r;
    @(posedge clock);
    #1 q.push_back(e);
    started = 1'b1;
  endtask

  // rst pulses low strictly between edges; the hold value must not change.
  task automatic pulse_step(input logic [3:0] e);
    rst = 1'b1;
    @(posedge clock);
    #1 q.push_back(e);
    #1 rst = 1'b0;
    #1 chk("pulse_hold", dout, e);
    #1 rst = 1'b1;
  endtask

  // Monitor
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clock);
      if (started) begin
        checks++;
        if ($countones(dout) != 1 || $isunknown(dout)) begin
          errors++;
          $display("FAIL onehot act=%b exp=one_hot t=%0t", dout, $time);
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seq", dout, e);
      end
    end
  end

  initial begin
    // Reset
    step(1'b0, 4'b0001);
    // Free run, 10 edges (includes wrap 1000 -> 0001)
    step(1'b1, 4'b0010); step(1'b1, 4'b0100); step(1'b1, 4'b1000);
    step(1'b1, 4'b0001); step(1'b1, 4'b0010); step(1'b1, 4'b0100);
    step(1'b1, 4'b1000); step(1'b1, 4'b0001); step(1'b1, 4'b0010);
    step(1'b1, 4'b0100);
    // Mid-sequence reset from 0100
    step(1'b0, 4'b0001); step(1'b1, 4'b0010);
    // Held reset
    step(1'b0, 4'b0001); step(1'b0, 4'b0001); step(1'b0, 4'b0001);
    step(1'b1, 4'b0010); step(1'b1, 4'b0100); step(1'b1, 4'b1000);
    step(1'b1, 4'b0001);
    // Unsampled rst pulses must not disturb the rotation
    pulse_step(4'b0010);
    pulse_step(4'b0100);
    step(1'b1, 4'b1000);
    pulse_step(4'b0001);
    step(1'b1, 4'b0010);
    // Random resets against a rotate-left model
    m = 4'b0010;
    for (int i = 0; i < 120; i++) begin
      logic r;
      r = ($urandom_range(0, 7) != 0);
      m = r ? {m[2:0], m[3]} : 4'b0001;
      step(r, m);
    end
    // Drain with a bound
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
